// File: rtl/mem_wb_stage.sv
// mem_wb_stage: data-memory access (M stage) and M->W pipeline register.
// Latency: one cycle from M-stage inputs to *_W outputs; memory reads are combinational,
//          so a store is visible to a load one cycle later. The stage never stalls or flushes.
// Ports: clk, reset (synchronous, active-low); M-stage IR/PC8/AO/RT/A3/RegWrite/MemWrite in;
//        registered IR_W, PC8_W, AO_W, DR_W (extended load data), A3_W, RegWrite_W, addr_err_W out.
// Optional feature: define MEM_ALIGN_CHECK_EN to flag and suppress misaligned accesses.
module mem_wb_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR_M,
    input  logic [31:0] PC8_M,
    input  logic [31:0] AO_M,
    input  logic [31:0] RT_M,
    input  logic [4:0]  A3_M,
    input  logic        RegWrite_M,
    input  logic        MemWrite_M,
    output logic [31:0] IR_W,
    output logic [31:0] PC8_W,
    output logic [31:0] AO_W,
    output logic [31:0] DR_W,
    output logic [4:0]  A3_W,
    output logic        RegWrite_W,
    output logic        addr_err_W
);
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;

    // Power-up values give a defined state before the first reset.
    logic [31:0] mem [0:4095] = '{default: 32'h0};
    logic [31:0] ir_q  = 32'h0;
    logic [31:0] pc8_q = 32'h0;
    logic [31:0] ao_q  = 32'h0;
    logic [31:0] dr_q  = 32'h0;
    logic [4:0]  a3_q  = 5'h0;
    logic        rw_q  = 1'b0;
    logic        err_q = 1'b0;

    logic [5:0]  op;
    logic [11:0] idx;
    logic [31:0] rd_word;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_data;
    logic        is_sb, is_sh, word_acc, half_acc;
    logic        misalign;
    logic        wr_en;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;

    assign op      = IR_M[31:26];
    assign idx     = AO_M[13:2];
    assign rd_word = mem[idx];
    assign is_sb   = (op == OP_SB);
    assign is_sh   = (op == OP_SH);

    // A write strobe on anything other than sb/sh is a full-word store.
    assign word_acc = (op == OP_LW) || (op == OP_SW) || (MemWrite_M && !is_sb && !is_sh);
    assign half_acc = (op == OP_LH) || (op == OP_LHU) || is_sh;

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = (word_acc && (AO_M[1:0] != 2'b00)) || (half_acc && AO_M[0]);
`else
    // Low address bits below the access size are simply not used (aligned down).
    assign misalign = 1'b0;
`endif

    always_comb begin
        rd_byte = rd_word[7:0];
        case (AO_M[1:0])
            2'd0: rd_byte = rd_word[7:0];
            2'd1: rd_byte = rd_word[15:8];
            2'd2: rd_byte = rd_word[23:16];
            2'd3: rd_byte = rd_word[31:24];
            default: rd_byte = rd_word[7:0];
        endcase
    end

    assign rd_half = AO_M[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_data = rd_word;
        case (op)
            OP_LB:   load_data = {{24{rd_byte[7]}}, rd_byte};
            OP_LBU:  load_data = {24'h0, rd_byte};
            OP_LH:   load_data = {{16{rd_half[15]}}, rd_half};
            OP_LHU:  load_data = {16'h0, rd_half};
            default: load_data = rd_word;
        endcase
    end

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        wr_be   = 4'b1111;
        wr_data = RT_M;
        if (is_sb) begin
            wr_data = {4{RT_M[7:0]}};
            case (AO_M[1:0])
                2'd0: wr_be = 4'b0001;
                2'd1: wr_be = 4'b0010;
                2'd2: wr_be = 4'b0100;
                2'd3: wr_be = 4'b1000;
                default: wr_be = 4'b0001;
            endcase
        end else if (is_sh) begin
            wr_data = {2{RT_M[15:0]}};
            wr_be   = AO_M[1] ? 4'b1100 : 4'b0011;
        end
    end

    assign wr_en = MemWrite_M && !misalign;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 4096; i++) begin
                mem[i[11:0]] <= 32'h0;
            end
        end else if (wr_en) begin
            if (wr_be[0]) mem[idx][7:0]   <= wr_data[7:0];
            if (wr_be[1]) mem[idx][15:8]  <= wr_data[15:8];
            if (wr_be[2]) mem[idx][23:16] <= wr_data[23:16];
            if (wr_be[3]) mem[idx][31:24] <= wr_data[31:24];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ir_q  <= 32'h0;
            pc8_q <= 32'h0;
            ao_q  <= 32'h0;
            dr_q  <= 32'h0;
            a3_q  <= 5'h0;
            rw_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            ir_q  <= IR_M;
            pc8_q <= PC8_M;
            ao_q  <= AO_M;
            dr_q  <= load_data;
            a3_q  <= A3_M;
            rw_q  <= RegWrite_M && !misalign;
            err_q <= misalign;
        end
    end

    assign IR_W       = ir_q;
    assign PC8_W      = pc8_q;
    assign AO_W       = ao_q;
    assign DR_W       = dr_q;
    assign A3_W       = a3_q;
    assign RegWrite_W = rw_q;
    assign addr_err_W = err_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;
    localparam logic [5:0] LW = 6'b100011, LB = 6'b100000, LBU = 6'b100100, LH = 6'b100001;
    localparam logic [5:0] LHU = 6'b100101, SW = 6'b101011, SB = 6'b101000, SH = 6'b101001;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] IR_M = '0, PC8_M = '0, AO_M = '0, RT_M = '0;
    logic [4:0]  A3_M = '0;
    logic        RegWrite_M = 1'b0, MemWrite_M = 1'b0;
    logic [31:0] IR_W, PC8_W, AO_W, DR_W;
    logic [4:0]  A3_W;
    logic        RegWrite_W, addr_err_W;

    mem_wb_stage dut (
        .clk(clk), .reset(reset),
        .IR_M(IR_M), .PC8_M(PC8_M), .AO_M(AO_M), .RT_M(RT_M), .A3_M(A3_M),
        .RegWrite_M(RegWrite_M), .MemWrite_M(MemWrite_M),
        .IR_W(IR_W), .PC8_W(PC8_W), .AO_W(AO_W), .DR_W(DR_W), .A3_W(A3_W),
        .RegWrite_W(RegWrite_W), .addr_err_W(addr_err_W)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;

    // Reference memory: byte-addressed view of a 16 KiB space.
    logic [7:0]  mref [0:16383];
    logic [31:0] exp_ir, exp_pc8, exp_ao, exp_dr;
    logic [4:0]  exp_a3;
    logic        exp_rw, exp_err;

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [13:0] b;
        b = {a[13:2], 2'b00};
        return {mref[b + 14'd3], mref[b + 14'd2], mref[b + 14'd1], mref[b]};
    endfunction

    task automatic clear_ref();
        for (int i = 0; i < 16384; i++) mref[i] = 8'h00;
    endtask

    // Present one M-stage instruction, predict the W-stage result, then advance one edge.
    task automatic drive(input logic [31:0] ir, input logic [31:0] ao, input logic [31:0] rt,
                         input logic mw, input logic rw, input logic [4:0] a3,
                         input logic [31:0] pc8);
        logic [5:0]  op;
        logic [31:0] w;
        logic [13:0] ba;
        logic [7:0]  bv;
        logic [15:0] hv;
        logic        wacc, hacc, mis;
        op = ir[31:26];
        w  = ref_word(ao);
        bv = w[8*ao[1:0] +: 8];
        hv = w[16*ao[1] +: 16];
        case (op)
            LB:      exp_dr = {{24{bv[7]}}, bv};
            LBU:     exp_dr = {24'h0, bv};
            LH:      exp_dr = {{16{hv[15]}}, hv};
            LHU:     exp_dr = {16'h0, hv};
            default: exp_dr = w;
        endcase
        wacc = (op == LW) || (op == SW) || (mw && op != SB && op != SH);
        hacc = (op == LH) || (op == LHU) || (op == SH);
`ifdef MEM_ALIGN_CHECK_EN
        mis = (wacc && ao[1:0] != 2'b00) || (hacc && ao[0]);
`else
        mis = 1'b0;
`endif
        exp_ir = ir; exp_pc8 = pc8; exp_ao = ao; exp_a3 = a3;
        exp_rw = rw && !mis;
        exp_err = mis;
        if (mw && !mis) begin
            ba = {ao[13:2], 2'b00};
            if (op == SB) mref[ba + {12'h0, ao[1:0]}] = rt[7:0];
            else if (op == SH) begin
                mref[ba + {12'h0, ao[1], 1'b0}]        = rt[7:0];
                mref[ba + {12'h0, ao[1], 1'b0} + 14'd1] = rt[15:8];
            end else begin
                for (int k = 0; k < 4; k++) mref[ba + 14'(k)] = rt[8*k +: 8];
            end
        end
        IR_M = ir; AO_M = ao; RT_M = rt; MemWrite_M = mw; RegWrite_M = rw; A3_M = a3; PC8_M = pc8;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        drive({SW, 26'h0}, 32'h10, 32'hCAFEF00D, 1'b1, 1'b0, 5'd0, 32'h0);
        drive({SW, 26'h0}, 32'h44, 32'h01020304, 1'b1, 1'b0, 5'd0, 32'h0);
        // Reset edge with a store and live fields presented: everything must clear.
        reset = 1'b0;
        IR_M = {SW, 26'h3}; AO_M = 32'h10; RT_M = 32'h11111111; MemWrite_M = 1'b1;
        RegWrite_M = 1'b1; A3_M = 5'd7; PC8_M = 32'h100;
        @(posedge clk);
        #1;
        clear_ref();
        n_checks++; if (IR_W !== 32'h0) $display("FAIL reset_IR_W got %h expected 0", IR_W); else n_pass++;
        n_checks++; if (PC8_W !== 32'h0) $display("FAIL reset_PC8_W got %h expected 0", PC8_W); else n_pass++;
        n_checks++; if (AO_W !== 32'h0) $display("FAIL reset_AO_W got %h expected 0", AO_W); else n_pass++;
        n_checks++; if (DR_W !== 32'h0) $display("FAIL reset_DR_W got %h expected 0", DR_W); else n_pass++;
        n_checks++; if (A3_W !== 5'h0) $display("FAIL reset_A3_W got %h expected 0", A3_W); else n_pass++;
        n_checks++; if (RegWrite_W !== 1'b0) $display("FAIL reset_RegWrite_W got %b expected 0", RegWrite_W); else n_pass++;
        n_checks++; if (addr_err_W !== 1'b0) $display("FAIL reset_addr_err_W got %b expected 0", addr_err_W); else n_pass++;
        reset = 1'b1;
        drive({LW, 26'h0}, 32'h10, 32'h0, 1'b0, 1'b1, 5'd3, 32'h8);
        n_checks++; if (DR_W !== 32'h0) $display("FAIL reset_lw10 got %h expected 00000000", DR_W); else n_pass++;
        drive({LW, 26'h0}, 32'h44, 32'h0, 1'b0, 1'b1, 5'd3, 32'h8);
        n_checks++; if (DR_W !== 32'h0) $display("FAIL reset_lw44 got %h expected 00000000", DR_W); else n_pass++;
    endtask

    task automatic test_word();
        drive({SW, 26'h0}, 32'h20, 32'hDEADBEEF, 1'b1, 1'b0, 5'd0, 32'h0);
        drive({LW, 26'h0}, 32'h20, 32'h0, 1'b0, 1'b1, 5'd4, 32'h0);
        n_checks++; if (DR_W !== 32'hDEADBEEF) $display("FAIL word_lw got %h expected deadbeef", DR_W); else n_pass++;
    endtask

    task automatic test_byte_half();
        drive({SB, 26'h0}, 32'h22, 32'h0000007F, 1'b1, 1'b0, 5'd0, 32'h0);
        drive({LW, 26'h0}, 32'h20, 32'h0, 1'b0, 1'b1, 5'd1, 32'h0);
        n_checks++; if (DR_W !== 32'hDE7FBEEF) $display("FAIL sb_lw got %h expected de7fbeef", DR_W); else n_pass++;
        drive({LB, 26'h0}, 32'h23, 32'h0, 1'b0, 1'b1, 5'd1, 32'h0);
        n_checks++; if (DR_W !== 32'hFFFFFFDE) $display("FAIL lb got %h expected ffffffde", DR_W); else n_pass++;
        drive({LBU, 26'h0}, 32'h23, 32'h0, 1'b0, 1'b1, 5'd1, 32'h0);
        n_checks++; if (DR_W !== 32'h000000DE) $display("FAIL lbu got %h expected 000000de", DR_W); else n_pass++;
        drive({LH, 26'h0}, 32'h20, 32'h0, 1'b0, 1'b1, 5'd1, 32'h0);
        n_checks++; if (DR_W !== 32'hFFFFBEEF) $display("FAIL lh got %h expected ffffbeef", DR_W); else n_pass++;
        drive({LHU, 26'h0}, 32'h22, 32'h0, 1'b0, 1'b1, 5'd1, 32'h0);
        n_checks++; if (DR_W !== 32'h0000DE7F) $display("FAIL lhu got %h expected 0000de7f", DR_W); else n_pass++;
        drive({SH, 26'h0}, 32'h22, 32'h0000A5C3, 1'b1, 1'b0, 5'd0, 32'h0);
        drive({LW, 26'h0}, 32'h20, 32'h0, 1'b0, 1'b1, 5'd1, 32'h0);
        n_checks++; if (DR_W !== 32'hA5C3BEEF) $display("FAIL sh_lw got %h expected a5c3beef", DR_W); else n_pass++;
    endtask

    task automatic test_wrap();
        drive({SW, 26'h0}, 32'h00004004, 32'h12345678, 1'b1, 1'b0, 5'd0, 32'h0);
        drive({LW, 26'h0}, 32'h4, 32'h0, 1'b0, 1'b1, 5'd5, 32'h0);
        n_checks++; if (DR_W !== 32'h12345678) $display("FAIL wrap got %h expected 12345678", DR_W); else n_pass++;
    endtask

    task automatic test_passthrough();
        drive(32'h00851020, 32'h55, 32'h0, 1'b0, 1'b1, 5'd2, 32'h3008);
        n_checks++; if (IR_W !== 32'h00851020) $display("FAIL pass_IR got %h expected 00851020", IR_W); else n_pass++;
        n_checks++; if (PC8_W !== 32'h3008) $display("FAIL pass_PC8 got %h expected 00003008", PC8_W); else n_pass++;
        n_checks++; if (AO_W !== 32'h55) $display("FAIL pass_AO got %h expected 00000055", AO_W); else n_pass++;
        n_checks++; if (A3_W !== 5'd2) $display("FAIL pass_A3 got %0d expected 2", A3_W); else n_pass++;
        n_checks++; if (RegWrite_W !== 1'b1) $display("FAIL pass_RegWrite got %b expected 1", RegWrite_W); else n_pass++;
        n_checks++; if (addr_err_W !== 1'b0) $display("FAIL pass_err got %b expected 0", addr_err_W); else n_pass++;
    endtask

    task automatic test_misalign();
        logic [31:0] want;
        drive({SW, 26'h0}, 32'h20, 32'hDEADBEEF, 1'b1, 1'b0, 5'd0, 32'h0);
        drive({SW, 26'h0}, 32'h21, 32'hAABBCCDD, 1'b1, 1'b1, 5'd0, 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
        n_checks++; if (addr_err_W !== 1'b1) $display("FAIL mis_err got %b expected 1", addr_err_W); else n_pass++;
        n_checks++; if (RegWrite_W !== 1'b0) $display("FAIL mis_rw got %b expected 0", RegWrite_W); else n_pass++;
        want = 32'hDEADBEEF;
`else
        n_checks++; if (addr_err_W !== 1'b0) $display("FAIL mis_err got %b expected 0", addr_err_W); else n_pass++;
        n_checks++; if (RegWrite_W !== 1'b1) $display("FAIL mis_rw got %b expected 1", RegWrite_W); else n_pass++;
        want = 32'hAABBCCDD;
`endif
        drive({LW, 26'h0}, 32'h20, 32'h0, 1'b0, 1'b1, 5'd1, 32'h0);
        n_checks++; if (DR_W !== want) $display("FAIL mis_lw got %h expected %h", DR_W, want); else n_pass++;
        n_checks++; if (addr_err_W !== 1'b0) $display("FAIL mis_err_clear got %b expected 0", addr_err_W); else n_pass++;
        // A non-store opcode with the write strobe set stores a full word.
        drive(32'h00000000, 32'h30, 32'h0BADF00D, 1'b1, 1'b0, 5'd0, 32'h0);
        drive({LW, 26'h0}, 32'h30, 32'h0, 1'b0, 1'b1, 5'd1, 32'h0);
        n_checks++; if (DR_W !== 32'h0BADF00D) $display("FAIL forced_sw got %h expected 0badf00d", DR_W); else n_pass++;
    endtask

    task automatic test_random();
        logic [5:0]  ops [10];
        logic [5:0]  op;
        logic [31:0] ao, ir;
        logic        mw;
        ops = '{LW, LB, LBU, LH, LHU, SW, SB, SH, 6'h00, 6'h0F};
        for (int n = 0; n < 300; n++) begin
            op = ops[$urandom_range(0, 9)];
            ao = {$urandom_range(0, 3) == 0 ? 18'($urandom) : 18'h0,
                  10'h0, 2'($urandom_range(0, 3)), 2'($urandom)};
            ir = {op, 26'($urandom)};
            mw = (op == SW || op == SB || op == SH) ||
                 ((op == 6'h00 || op == 6'h0F) && $urandom_range(0, 2) == 0);
            drive(ir, ao, $urandom, mw, 1'($urandom), 5'($urandom), $urandom);
            n_checks++;
            if (DR_W !== exp_dr) $display("FAIL rnd_DR n=%0d got %h expected %h", n, DR_W, exp_dr);
            else n_pass++;
            n_checks++;
            if ({IR_W, PC8_W, AO_W, A3_W, RegWrite_W, addr_err_W} !==
                {exp_ir, exp_pc8, exp_ao, exp_a3, exp_rw, exp_err})
                $display("FAIL rnd_fields n=%0d got %h/%h/%h/%h/%b/%b expected %h/%h/%h/%h/%b/%b", n,
                         IR_W, PC8_W, AO_W, A3_W, RegWrite_W, addr_err_W,
                         exp_ir, exp_pc8, exp_ao, exp_a3, exp_rw, exp_err);
            else n_pass++;
        end
    endtask

    initial begin
        clear_ref();
        test_reset();
        test_word();
        test_byte_half();
        test_wrap();
        test_passthrough();
        test_misalign();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; every register updates on its rising edge.
REQ-002 SHALL have port reset, input, 1; reset is synchronous and active-low (0 = reset), sampled on the rising edge of clk.
REQ-003 SHALL have inputs IR_M (32), PC8_M (32), AO_M (32), RT_M (32), A3_M (5), RegWrite_M (1) and MemWrite_M (1), carrying the instruction in the M stage, PC+8, ALU result/address, store data, destination register, register-write enable and memory-write enable.
REQ-004 SHALL have outputs IR_W (32), PC8_W (32), AO_W (32), DR_W (32), A3_W (5), RegWrite_W (1) and addr_err_W (1), all registered, carrying the same fields into the W stage, plus the extended load data and an alignment-error flag.

Function
REQ-005 SHALL contain a data memory of 4096 x 32-bit words, indexed by AO_M[13:2]; AO_M[31:14] is ignored, so addresses wrap modulo 16 KiB.
REQ-006 SHALL decode the access type from IR_M[31:26]: lw 100011, lb 100000, lbu 100100, lh 100001, lhu 100101, sw 101011, sb 101000, sh 101001; any other opcode is a non-memory instruction.
REQ-007 SHALL write on the rising edge when reset=1 and MemWrite_M=1, with byte enables as follows.
- sw: all 4 bytes.
- sh: bytes {1,0} if AO_M[1]=0, else bytes {3,2}; data RT_M[15:0].
- sb: the byte selected by AO_M[1:0]; data RT_M[7:0].
- Unselected bytes are kept.
REQ-008 SHALL read the addressed word combinationally in the M stage. Before it is registered into DR_W, the selected byte or halfword is extended: sign extension for lb and lh, zero extension for lbu and lhu, the full word for lw, and the full unextended word for non-load opcodes.
REQ-009 Latency SHALL be one cycle: the M-stage inputs are captured into the *_W outputs at the edge that ends the M cycle, and DR_W becomes valid in the same cycle.
REQ-010 A load in the cycle immediately after a store to the same word SHALL return the newly written data; the write completes at the edge and the read is combinational.
REQ-011 MemWrite_M=1 with a non-store opcode SHALL be treated as sw.
REQ-012 The stage SHALL not stall or flush; every cycle with reset=1 advances.

Reset
REQ-013 When reset=0 at a rising edge, SHALL clear IR_W, PC8_W, AO_W, DR_W, A3_W, RegWrite_W and addr_err_W to 0.
REQ-014 When reset=0 at a rising edge, SHALL clear all 4096 memory words to 0 and suppress any write presented in that cycle.
REQ-015 At simulation start, SHALL initialize all outputs and memory to 0.
REQ-016 If reset is asserted while a store sits in M, SHALL drop the store, and memory SHALL read as 0 afterward.

Configuration
REQ-017 Macro MEM_ALIGN_CHECK_EN SHALL control alignment checking.
REQ-018 With MEM_ALIGN_CHECK_EN defined, a misaligned access SHALL suppress the memory write, force RegWrite_W=0 and set addr_err_W=1 for one cycle; the other *_W fields pass through unchanged. An access is misaligned when:
- it is lw or sw with AO_M[1:0] != 0, or
- it is lh, lhu or sh with AO_M[0] = 1.
REQ-019 Without MEM_ALIGN_CHECK_EN, SHALL tie addr_err_W to 0 and ignore the low address bits below the access size (force alignment down); no suppression occurs.

Verification
REQ-020 Reset: hold reset=0 for one edge after arbitrary writes, then lw from 0x10 -> DR_W=0x00000000 and all *_W outputs are 0 during reset.
REQ-021 Word path: sw RT_M=0xDEADBEEF to AO_M=0x20, next cycle lw 0x20 -> DR_W=0xDEADBEEF.
REQ-022 Byte/half path, with word 0x20 = 0xDEADBEEF:
- sb 0x7F to 0x22, then lw 0x20 -> 0xDE7FBEEF.
- lb 0x23 -> 0xFFFFFFDE.
- lbu 0x23 -> 0x000000DE.
- lh 0x20 -> 0xFFFFBEEF.
- lhu 0x22 -> 0x0000DE7F.
REQ-023 Wrap: sw 0x12345678 to AO_M=0x00004004, then lw 0x4 -> DR_W=0x12345678.
REQ-024 Passthrough: with IR_M=0x00851020, PC8_M=0x3008, A3_M=2, RegWrite_M=1 and AO_M=0x55, the next cycle shows identical *_W values and AO_W=0x55.
REQ-025 Misalignment: sw to 0x21, then lw 0x20.
- With MEM_ALIGN_CHECK_EN: addr_err_W=1, RegWrite_W=0 and memory is unchanged.
- Without: the write lands at 0x20 and addr_err_W=0.
